// File: rtl/pin_input_monitor.sv
// Four-pin GPIO input monitor: two-flop synchroniser, per-pin debounce on a 1 ms
// tick, sticky rise/fall status with write-1-to-clear, and a level interrupt.
module pin_input_monitor #(
    parameter logic [13:0] TERMINAL_CNT_1MS = 14'd11999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pin_in,
    input  logic [7:0] debounce_ms,
    input  logic [3:0] rise_en,
    input  logic [3:0] fall_en,
    input  logic [3:0] sts_clr,
    output logic [3:0] pin_state,
    output logic [3:0] rise_sts,
    output logic [3:0] fall_sts,
    output logic       irq
);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [13:0] r_presc;
    logic [3:0]  r_pin_state;
    logic [3:0]  r_pin_prev;
    logic [7:0]  r_stable_cnt [4];
    logic [3:0]  r_rise_sts;
    logic [3:0]  r_fall_sts;

    logic        w_tick;
    logic [7:0]  w_db_m1;
    logic [3:0]  w_rise_evt;
    logic [3:0]  w_fall_evt;

    assign w_tick     = (r_presc == TERMINAL_CNT_1MS);
    // only consulted when debounce_ms is non-zero, so the wrap at 0 is harmless
    assign w_db_m1    = debounce_ms - 8'd1;
    assign w_rise_evt = r_pin_state & ~r_pin_prev;
    assign w_fall_evt = ~r_pin_state & r_pin_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pin_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 14'd1;
        end
    end

    // A level is accepted on the debounce_ms-th tick it is continuously present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pin_state <= '0;
            for (int i = 0; i < 4; i++) begin
                r_stable_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (debounce_ms == 8'd0) begin
                    r_pin_state[i]  <= r_sync2[i];
                    r_stable_cnt[i] <= '0;
                end else if (r_sync2[i] == r_pin_state[i]) begin
                    r_stable_cnt[i] <= '0;
                end else if (w_tick) begin
                    if (r_stable_cnt[i] >= w_db_m1) begin
                        r_pin_state[i]  <= r_sync2[i];
                        r_stable_cnt[i] <= '0;
                    end else begin
                        r_stable_cnt[i] <= r_stable_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pin_prev <= '0;
            r_rise_sts <= '0;
            r_fall_sts <= '0;
        end else begin
            r_pin_prev <= r_pin_state;
            r_rise_sts <= (w_rise_evt & rise_en) | (r_rise_sts & ~sts_clr);
            r_fall_sts <= (w_fall_evt & fall_en) | (r_fall_sts & ~sts_clr);
        end
    end

    assign pin_state = r_pin_state;
    assign rise_sts  = r_rise_sts;
    assign fall_sts  = r_fall_sts;
    assign irq       = |{r_rise_sts, r_fall_sts};

endmodule

// File: tb/tb_pin_input_monitor.sv
// Bench for pin_input_monitor: directed scenarios plus randomized pin activity
// compared against a tick-counting reference model.
module tb_pin_input_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] pin_in;
    logic [7:0] debounce_ms;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic [3:0] sts_clr;
    logic [3:0] pin_state;
    logic [3:0] rise_sts;
    logic [3:0] fall_sts;
    logic       irq;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    pin_input_monitor #(.TERMINAL_CNT_1MS(14'd9)) dut (
        .clk         (clk),
        .rst         (rst),
        .pin_in      (pin_in),
        .debounce_ms (debounce_ms),
        .rise_en     (rise_en),
        .fall_en     (fall_en),
        .sts_clr     (sts_clr),
        .pin_state   (pin_state),
        .rise_sts    (rise_sts),
        .fall_sts    (fall_sts),
        .irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: time since reset decides the 1 ms ticks; each pin tracks
    // how many ticks a differing synchronised level has been seen in a row.
    int         m_cyc;
    logic [3:0] m_s1, m_s2, m_state, m_prev, m_rise, m_fall;
    int         m_q [4];
    bit         m_tick;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_s1 = 0; m_s2 = 0; m_state = 0; m_prev = 0;
            m_rise = 0; m_fall = 0;
            for (int i = 0; i < 4; i++) m_q[i] = 0;
        end else begin
            m_tick = ((m_cyc % 10) == 9);
            m_cyc  = m_cyc + 1;
            m_rise = ((m_state & ~m_prev) & rise_en) | (m_rise & ~sts_clr);
            m_fall = ((~m_state & m_prev) & fall_en) | (m_fall & ~sts_clr);
            m_prev = m_state;
            for (int i = 0; i < 4; i++) begin
                if (debounce_ms == 0) begin
                    m_state[i] = m_s2[i];
                    m_q[i] = 0;
                end else if (m_s2[i] == m_state[i]) begin
                    m_q[i] = 0;
                end else if (m_tick) begin
                    if (m_q[i] + 1 >= int'(debounce_ms)) begin
                        m_state[i] = m_s2[i];
                        m_q[i] = 0;
                    end else begin
                        m_q[i] = m_q[i] + 1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = pin_in;
        end
    end

    task automatic clear_all_sts();
        sts_clr = 4'hF;
        @(negedge clk);
        sts_clr = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; pin_in = 4'hF; debounce_ms = 8'd0;
        rise_en = 4'hF; fall_en = 4'hF; sts_clr = 4'h0;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if ({pin_state, rise_sts, fall_sts, irq} !== 13'd0)
            $display("FAIL reset_outputs: got %h/%h/%h/%b want 0", pin_state, rise_sts, fall_sts, irq);
        else pass_cnt++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (pin_state !== 4'h0) $display("FAIL reset_latency_early: pin_state=%h want 0", pin_state);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (pin_state !== 4'hF) $display("FAIL reset_latency_3clk: pin_state=%h want f", pin_state);
        else pass_cnt++;
        chk_cnt++;
        if (rise_sts !== 4'h0) $display("FAIL reset_rise_early: rise_sts=%h want 0", rise_sts);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (rise_sts !== 4'hF || irq !== 1'b1)
            $display("FAIL reset_rise_sts: rise_sts=%h irq=%b want f/1", rise_sts, irq);
        else pass_cnt++;
    endtask

    task automatic test_debounce_accept();
        int n;
        pin_in = 4'h0;
        repeat (6) @(negedge clk);
        clear_all_sts();
        debounce_ms = 8'd3;
        pin_in = 4'h1;
        n = 0;
        while (pin_state[0] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (n - 2 < 21 || n - 2 > 30)
            $display("FAIL debounce_accept_window: accepted %0d clks after sync2, want 21..30", n - 2);
        else pass_cnt++;
        chk_cnt++;
        if (rise_sts[0] !== 1'b0) $display("FAIL debounce_rise_early: rise_sts=%h want bit0=0", rise_sts);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (rise_sts[0] !== 1'b1) $display("FAIL debounce_rise_sts: rise_sts=%h want bit0=1", rise_sts);
        else pass_cnt++;
    endtask

    task automatic test_bounce_reject();
        bit seen_high = 0;
        debounce_ms = 8'd3;
        clear_all_sts();
        for (int r = 0; r < 3; r++) begin
            pin_in = 4'h3;
            repeat (15) begin @(negedge clk); if (pin_state[1]) seen_high = 1; end
            pin_in = 4'h1;
            repeat (5) begin @(negedge clk); if (pin_state[1]) seen_high = 1; end
        end
        repeat (40) begin @(negedge clk); if (pin_state[1]) seen_high = 1; end
        chk_cnt++;
        if (seen_high) $display("FAIL bounce_pin_state: pin_state[1] went 1 want stay 0");
        else pass_cnt++;
        chk_cnt++;
        if (rise_sts[1] !== 1'b0 || fall_sts[1] !== 1'b0)
            $display("FAIL bounce_sts: rise_sts=%h fall_sts=%h want bit1=0", rise_sts, fall_sts);
        else pass_cnt++;
    endtask

    task automatic test_enables_clear();
        rise_en = 4'h0; fall_en = 4'h4; debounce_ms = 8'd0;
        clear_all_sts();
        pin_in = 4'h5;
        repeat (4) @(negedge clk);
        pin_in = 4'h1;
        repeat (6) @(negedge clk);
        chk_cnt++;
        if (rise_sts !== 4'h0 || fall_sts !== 4'h4 || irq !== 1'b1)
            $display("FAIL enables_capture: rise=%h fall=%h irq=%b want 0/4/1", rise_sts, fall_sts, irq);
        else pass_cnt++;
        sts_clr = 4'h4;
        @(negedge clk);
        sts_clr = 4'h0;
        chk_cnt++;
        if (fall_sts !== 4'h0 || irq !== 1'b0)
            $display("FAIL enables_w1c: fall=%h irq=%b want 0/0", fall_sts, irq);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        rise_en = 4'hF; fall_en = 4'hF; debounce_ms = 8'd0;
        pin_in = 4'h9;
        repeat (3) @(negedge clk);
        sts_clr = 4'h8;
        @(negedge clk);
        sts_clr = 4'h0;
        chk_cnt++;
        if (rise_sts[3] !== 1'b1) $display("FAIL collision_set_wins: rise_sts=%h want bit3=1", rise_sts);
        else pass_cnt++;
        rise_en = 4'h0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (rise_sts[3] !== 1'b1) $display("FAIL enable_off_keeps: rise_sts=%h want bit3=1", rise_sts);
        else pass_cnt++;
        sts_clr = 4'h8;
        @(negedge clk);
        sts_clr = 4'h0;
        chk_cnt++;
        if (rise_sts[3] !== 1'b0) $display("FAIL collision_clear: rise_sts=%h want bit3=0", rise_sts);
        else pass_cnt++;
        rise_en = 4'hF;
    endtask

    task automatic test_midop_reset();
        int n;
        debounce_ms = 8'd0;
        pin_in = 4'h0;
        repeat (6) @(negedge clk);
        clear_all_sts();
        debounce_ms = 8'd3;
        pin_in = 4'h1;
        n = 0;
        while (m_q[0] != 2 && n < 60) begin @(negedge clk); n++; end
        chk_cnt++;
        if (m_q[0] != 2) $display("FAIL midop_reach_cnt2: timed out after %0d clks", n);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({pin_state, rise_sts, fall_sts, irq} !== 13'd0)
            $display("FAIL midop_async_clear: got %h/%h/%h/%b want 0", pin_state, rise_sts, fall_sts, irq);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (pin_state[0] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk_cnt++;
        if (n != 30) $display("FAIL midop_full_requal: accepted after %0d clks want 30", n);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if ({pin_state, rise_sts, fall_sts, irq} !== {m_state, m_rise, m_fall, |{m_rise, m_fall}}) begin
                if (errs < 5)
                    $display("FAIL random_cyc%0d: dut %h/%h/%h/%b want %h/%h/%h/%b", c,
                             pin_state, rise_sts, fall_sts, irq, m_state, m_rise, m_fall, |{m_rise, m_fall});
                errs++;
            end
            if ($urandom_range(0, 7) == 0) pin_in[$urandom_range(0, 3)] = ~pin_in[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) pin_in = $urandom();
            if ($urandom_range(0, 299) == 0) debounce_ms = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin rise_en = $urandom(); fall_en = $urandom(); end
            sts_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom()) : 4'h0;
        end
        chk_cnt++;
        if (errs != 0) $display("FAIL random_total: %0d mismatching cycles want 0", errs);
        else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce_accept();
        test_bounce_reject();
        test_enables_clear();
        test_collision();
        test_midop_reset();
        debounce_ms = 8'd2;
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pin_input_monitor.md
Name: pin_input_monitor

Overview:
- Input-side companion to the LED/port output controller: samples four external GPIO pins, synchronises and debounces them, and reports the filtered level.
- Latches sticky rise/fall event status per pin, with per-pin edge enables and a write-1-to-clear interface.
- Drives a single level interrupt to the register/bus layer.
- Shares the 1 ms timebase convention of the output controller: 12 MHz clock, prescaled to a 1 ms tick.

Parameters:
- TERMINAL_CNT_1MS, 14'd11999, terminal count of the 1 ms prescaler (period = value+1 clocks).

Ports:
- clk  in  1  system clock, 12 MHz nominal.
- rst  in  1  asynchronous active-low reset; all flops clear while low.
- pin_in  in  4  raw asynchronous pin levels, bit i = pin i.
- debounce_ms  in  8  stable time required before accepting a new level, in 1 ms ticks; 0 = bypass.
- rise_en  in  4  per-pin enable for rising-edge status capture.
- fall_en  in  4  per-pin enable for falling-edge status capture.
- sts_clr  in  4  one-clock pulse; bit i clears rise_sts[i] and fall_sts[i].
- pin_state  out  4  debounced pin levels.
- rise_sts  out  4  sticky rising-edge flags.
- fall_sts  out  4  sticky falling-edge flags.
- irq  out  1  OR of all rise_sts and fall_sts bits.

Behaviour:
- Reset (rst low, async):
  - sync stages, pin_state, rise_sts, fall_sts, prescaler, all stable counters = 0.
  - irq = 0.
  - Release is synchronous to the next clk edge.
- Synchroniser: two flops per pin, sync1 <= pin_in, sync2 <= sync1.
- Prescaler:
  - Free-running counter 0..TERMINAL_CNT_1MS; wraps to 0.
  - tick = 1 for exactly the cycle in which the count equals TERMINAL_CNT_1MS.
  - Never gated.
- Debounce, per pin i, 8-bit stable_cnt[i]:
  - debounce_ms == 0: pin_state[i] <= sync2[i] every clock; stable_cnt[i] <= 0. pin_in to pin_state latency is 3 clocks.
  - sync2[i] == pin_state[i]: stable_cnt[i] <= 0 (any bounce back restarts qualification).
  - sync2[i] != pin_state[i], tick = 0: hold stable_cnt[i].
  - sync2[i] != pin_state[i], tick = 1, stable_cnt[i] >= debounce_ms-1: pin_state[i] <= sync2[i]; stable_cnt[i] <= 0.
  - sync2[i] != pin_state[i], tick = 1, otherwise: stable_cnt[i] <= stable_cnt[i] + 1.
  - Net effect: a new level is accepted on the debounce_ms-th tick it is continuously present, i.e. (debounce_ms-1, debounce_ms] ms after reaching sync2.
  - The >= compare makes a mid-qualification reduction of debounce_ms take effect on the next tick; no overflow is possible.
- Edge status, per pin i:
  - rise_evt = pin_state[i] goes 0->1 (registered compare against the previous pin_state); fall_evt likewise for 1->0.
  - Sticky flag updates one clock after pin_state changes.
  - rise_sts[i] <= (rise_evt & rise_en[i]) | (rise_sts[i] & ~sts_clr[i]); fall_sts identical with fall_evt/fall_en.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Clearing enable bits does not clear already-set flags.
- irq: combinational OR of the 8 status flags; no glitch paths beyond the registers.
- Pins are independent; simultaneous events on multiple pins all captured in the same cycle.
- Reset mid-qualification discards partial counts and any pending status.

Test Plan:
- Bench uses TERMINAL_CNT_1MS=9 (tick every 10 clks).
- Reset: hold rst low with pin_in=4'hF -> all outputs 0; after release with debounce_ms=0, pin_state=4'hF exactly 3 clks later; rise_sts=4'hF, irq=1 one clk after that (rise_en=4'hF).
- Debounce accept: debounce_ms=3, pin_in[0] 0->1 held -> pin_state[0]=1 on 3rd tick after sync2 changes (21-30 clks); rise_sts[0]=1 next clk.
- Bounce reject: debounce_ms=3, pin_in[1] pulses high for 15 clks, repeated 3 times with 5-clk low gaps -> pin_state[1] stays 0, fall_sts/rise_sts stay 0.
- Enables/clear: rise_en=0, fall_en=4'h4, pin 2 toggles 0->1->0 with debounce_ms=0 -> only fall_sts[2]=1, irq=1; sts_clr=4'h4 pulse -> fall_sts=0, irq=0 next clk.
- Set/clear collision: sts_clr[3] asserted in the same cycle as a rise_evt on pin 3 -> rise_sts[3] remains 1.
- Mid-op reset: drop rst during qualification of pin 0 (stable_cnt=2) -> immediate zeroing; after release, the pin needs a full debounce_ms again before acceptance.
